// File: rtl/onchip_ram_pipelined.sv
// Single-port on-chip RAM with byte-lane writes and an in-order read pipeline of 1 or 2 stages.
// Everything stalls on a global enable, and the RAM can optionally zero-fill itself after reset.
`default_nettype none

module onchip_ram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 14,
    parameter int DEPTH          = 10240,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 0,
    parameter     INIT_FILE      = "onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    input  logic                    reset_req,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    busy
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  clear_addr;
    logic [IDX_W-1:0]  clear_addr_next;
    logic              clear_write;

    logic              en;
    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;
    logic              write_accept;
    logic              read_accept;
    logic [DATA_WIDTH-1:0] read_word;

    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    assign en       = clken & ~reset_req;
    assign in_range = {1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH);
    assign mem_idx  = address[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clear_addr <= '0;
        end else begin
            state      <= state_next;
            clear_addr <= clear_addr_next;
        end
    end

    // While reset is held the handshake outputs show the state the RAM will
    // come out of reset in, and nothing may touch the memory.
    always_comb begin
        state_next      = state;
        clear_addr_next = clear_addr;
        clear_write     = 1'b0;
        busy            = 1'b0;
        waitrequest     = ~en;
        unique case (state)
            CLEAR: begin
                busy        = 1'b1;
                waitrequest = 1'b1;
                if (en && reset_n) begin
                    clear_write = 1'b1;
                    if (clear_addr == LAST_IDX) begin
                        state_next = READY;
                    end else begin
                        clear_addr_next = clear_addr + 1'b1;
                    end
                end
            end
            READY: begin
                busy = 1'b0;
            end
            default: begin
                state_next = READY;
            end
        endcase
        if (!reset_n) begin
            waitrequest = (CLEAR_ON_RESET != 0);
        end
    end

    assign write_accept = reset_n & chipselect & write & ~waitrequest;
    assign read_accept  = reset_n & chipselect & read & ~write & ~waitrequest;

    always_ff @(posedge clk) begin
        if (clear_write) begin
            mem[clear_addr] <= '0;
        end else if (write_accept && in_range) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (byteenable[i]) begin
                    mem[mem_idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // Addresses past the implemented words read as zero. The read samples the
    // array before this edge's write lands, so read-during-write returns old data.
    assign read_word = in_range ? mem[mem_idx] : '0;

    // Stage data only moves with a valid word, so readdata keeps the last
    // delivered value between transfers; the whole pipe freezes while en is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_data[s] <= '0;
            end
        end else if (en) begin
            pipe_valid[0] <= read_accept;
            if (read_accept) begin
                pipe_data[0] <= read_word;
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                if (pipe_valid[s-1]) begin
                    pipe_data[s] <= pipe_data[s-1];
                end
            end
        end
    end

    assign readdata      = pipe_data[READ_LATENCY-1];
    assign readdatavalid = pipe_valid[READ_LATENCY-1] & en;

endmodule

`default_nettype wire

// File: tb/tb_onchip_ram_pipelined.sv
// Bench for onchip_ram_pipelined: three instances (defaults, two-cycle read latency, small
// self-clearing RAM) share one stimulus stream and are scored against a per-instance memory model.
module tb_onchip_ram_pipelined;

    localparam int AW   = 14;
    localparam int NDUT = 3;

    typedef struct {
        int          id;
        int          due;
        logic [31:0] data;
    } rd_entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          chipselect;
    logic          read;
    logic          write;
    logic          clken;
    logic          reset_req;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic [31:0]   writedata;

    logic [31:0] rd_a, rd_b, rd_c;
    logic        rdv_a, rdv_b, rdv_c;
    logic        wait_a, wait_b, wait_c;
    logic        busy_a, busy_b, busy_c;

    onchip_ram_pipelined dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .readdata(rd_a), .readdatavalid(rdv_a),
        .waitrequest(wait_a), .busy(busy_a)
    );

    onchip_ram_pipelined #(.READ_LATENCY(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .readdata(rd_b), .readdatavalid(rdv_b),
        .waitrequest(wait_b), .busy(busy_b)
    );

    onchip_ram_pipelined #(.DEPTH(16), .CLEAR_ON_RESET(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .readdata(rd_c), .readdatavalid(rdv_c),
        .waitrequest(wait_c), .busy(busy_c)
    );

    int          checks = 0;
    int          errors = 0;
    rd_entry_t   exp_q[$];
    logic [31:0] mem_ab [int];
    logic [31:0] mem_c [16];
    logic [31:0] last_rd [NDUT];
    int          clear_left = 16;
    int          en_idx = 0;

    function automatic int latOf(input int id);
        return (id == 1) ? 2 : 1;
    endfunction

    function automatic int depthOf(input int id);
        return (id == 2) ? 16 : 10240;
    endfunction

    function automatic logic [31:0] modelRead(input int id, input int addr);
        if (addr >= depthOf(id)) return 32'h0;
        if (id == 2) return mem_c[addr];
        return mem_ab.exists(addr) ? mem_ab[addr] : 32'h0;
    endfunction

    task automatic modelWrite(input int id, input int addr, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] w;
        w = modelRead(id, addr);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
        end
        if (id == 2) mem_c[addr] = w;
        else mem_ab[addr] = w;
    endtask

    task automatic checkValue(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d: observed %h expected %h", tag, id, obs, exp);
        end
    endtask

    // Called mid-cycle: compare this cycle's outputs, then account for what the edge will accept.
    task automatic checkOutput();
        logic        en;
        logic        exp_v;
        logic [31:0] exp_d;
        logic        clearing;
        logic        ready;
        logic [31:0] obs_rd [NDUT];
        logic        obs_rdv [NDUT];
        logic        obs_wait [NDUT];
        logic        obs_busy [NDUT];

        obs_rd[0] = rd_a;     obs_rd[1] = rd_b;     obs_rd[2] = rd_c;
        obs_rdv[0] = rdv_a;   obs_rdv[1] = rdv_b;   obs_rdv[2] = rdv_c;
        obs_wait[0] = wait_a; obs_wait[1] = wait_b; obs_wait[2] = wait_c;
        obs_busy[0] = busy_a; obs_busy[1] = busy_b; obs_busy[2] = busy_c;

        en = clken & ~reset_req;
        if (!reset_n) begin
            exp_q.delete();
            for (int id = 0; id < NDUT; id++) last_rd[id] = 32'h0;
            clear_left = 16;
        end

        for (int id = 0; id < NDUT; id++) begin
            exp_v = 1'b0;
            exp_d = last_rd[id];
            if (reset_n && en) begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (exp_q[k].id == id && exp_q[k].due == en_idx) begin
                        exp_v = 1'b1;
                        exp_d = exp_q[k].data;
                        exp_q.delete(k);
                        break;
                    end
                end
            end
            checkValue("readdatavalid", id, 32'(obs_rdv[id]), 32'(exp_v));
            if (!reset_n) begin
                checkValue("readdata_reset", id, obs_rd[id], 32'h0);
            end else if (exp_v) begin
                checkValue("readdata", id, obs_rd[id], exp_d);
                last_rd[id] = exp_d;
            end else if (en) begin
                checkValue("readdata_hold", id, obs_rd[id], last_rd[id]);
            end
            clearing = (id == 2) && (clear_left > 0);
            checkValue("waitrequest", id, 32'(obs_wait[id]),
                       32'(!reset_n ? (id == 2) : (clearing || !en)));
            checkValue("busy", id, 32'(obs_busy[id]), 32'(clearing));
        end

        if (reset_n && en) begin
            for (int id = 0; id < NDUT; id++) begin
                ready = (id != 2) || (clear_left == 0);
                if (ready && chipselect) begin
                    if (write) begin
                        if (id != 1 && int'(address) < depthOf(id))
                            modelWrite(id, int'(address), byteenable, writedata);
                    end else if (read) begin
                        exp_q.push_back('{id, en_idx + latOf(id), modelRead(id, int'(address))});
                    end
                end
            end
            if (clear_left > 0) begin
                clear_left--;
                if (clear_left == 0) begin
                    for (int i = 0; i < 16; i++) mem_c[i] = 32'h0;
                end
            end
        end
        if (en) en_idx++;
    endtask

    task automatic applyStimulus(input logic rn, input logic ck, input logic rq, input logic cs,
                                 input logic rd, input logic wr, input logic [AW-1:0] addr,
                                 input logic [3:0] be, input logic [31:0] wd);
        reset_n    = rn;
        clken      = ck;
        reset_req  = rq;
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = addr;
        byteenable = be;
        writedata  = wd;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, addr, be, wd);
    endtask

    task automatic doRead(input logic [AW-1:0] addr);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, addr, 4'h0, 32'h0);
    endtask

    initial begin
        int          sel;
        logic [AW-1:0] ra;

        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; address = '0; byteenable = '0; writedata = '0;
        @(posedge clk);
        #1;

        $display("[TB] reset and first clear, aborted at clear address 7");
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) doWrite(AW'(i), 4'hF, $urandom);
        doRead(AW'(0));
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);

        $display("[TB] restarted clear, remaining preload");
        for (int i = 6; i < 16; i++) doWrite(AW'(i), 4'hF, $urandom);
        repeat (7) idleCycle();

        $display("[TB] read back all 16 words");
        for (int i = 0; i < 16; i++) doRead(AW'(i));
        repeat (3) idleCycle();

        $display("[TB] byte-lane merge on address 5");
        doWrite(AW'(5), 4'hF, 32'hDEADBEEF);
        doWrite(AW'(5), 4'h1, 32'h000000AA);
        doRead(AW'(5));
        checkValue("deadbeaa_data", 0, rd_a, 32'hDEADBEAA);
        checkValue("deadbeaa_valid", 0, 32'(rdv_a), 32'h1);
        idleCycle();

        $display("[TB] back-to-back reads 0,1,2");
        doRead(AW'(0));
        doRead(AW'(1));
        doRead(AW'(2));
        repeat (3) idleCycle();

        $display("[TB] out-of-range read and write");
        doRead(AW'(10240));
        doWrite(AW'(10240), 4'hF, 32'h12345678);
        doRead(AW'(0));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, AW'(7), 4'hF, 32'hCAFEF00D);
        doRead(AW'(7));
        repeat (2) idleCycle();

        $display("[TB] clock enable stall with a read in flight");
        doRead(AW'(3));
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, AW'(4), 4'h0, 32'h0);
        repeat (3) idleCycle();
        doRead(AW'(9));
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, AW'(4), 4'h0, 32'h0);
        repeat (3) idleCycle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 17);
            ra  = (sel < 16) ? AW'(sel) : ((sel == 16) ? AW'(10240) : AW'(16383));
            applyStimulus(1'b1, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0, ra, 4'($urandom), $urandom);
        end
        repeat (4) idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onchip_ram_pipelined.md
ONCHIP_RAM_PIPELINED -- requirements
Module: onchip_ram_pipelined

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width; a multiple of 8, range 8..128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14: word-address width.
REQ-003 SHALL have parameter DEPTH, default 10240: implemented words; DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1: cycles from read accept to readdatavalid; legal values 1 and 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 0: when 1, zero-fill the memory after every reset.
REQ-006 SHALL have parameter INIT_FILE, default "onchip_ram.hex": power-up contents.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port address, input, ADDR_WIDTH bits: word address.
REQ-010 SHALL have port byteenable, input, DATA_WIDTH/8 bits: write byte lanes.
REQ-011 SHALL have port chipselect, input, 1 bit: qualifies read and write.
REQ-012 SHALL have ports read and write, input, 1 bit each: transfer requests.
REQ-013 SHALL have port writedata, input, DATA_WIDTH bits: write data.
REQ-014 SHALL have port clken, input, 1 bit: global clock enable.
REQ-015 SHALL have port reset_req, input, 1 bit: request to quiesce the RAM.
REQ-016 SHALL have port readdata, output, DATA_WIDTH bits: registered read data.
REQ-017 SHALL have port readdatavalid, output, 1 bit: readdata qualifier.
REQ-018 SHALL have port waitrequest, output, 1 bit: request not accepted this cycle.
REQ-019 SHALL have port busy, output, 1 bit: clear sequence in progress.

Function
REQ-020 SHALL define en = clken & ~reset_req; with en low, no state SHALL change (pipeline, FSM, memory), waitrequest = 1 and readdatavalid = 0.
REQ-021 SHALL run a FSM with states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
REQ-022 In CLEAR, SHALL write all-zero data to one word per en cycle, addresses 0 up to DEPTH-1 ascending, with busy = 1 and waitrequest = 1.
REQ-023 After writing address DEPTH-1, SHALL enter READY on the next edge, and SHALL remain in READY until reset.
REQ-024 In READY, waitrequest SHALL equal ~en and busy SHALL be 0.
REQ-025 A write SHALL be accepted when chipselect & write & ~waitrequest; only lanes with byteenable[i] = 1 are updated, taking byte writedata[8i+7:8i].
REQ-026 A read SHALL be accepted when chipselect & read & ~write & ~waitrequest.
REQ-027 For an accepted read, readdata SHALL present the word READ_LATENCY en cycles later, with readdatavalid = 1 for exactly one cycle.
REQ-028 Reads SHALL be fully pipelined: one accept per cycle, returned in order, with no bubbles.
REQ-029 Read-during-write to the same address SHALL return the old data.
REQ-030 If read and write are both high, the write SHALL be performed and the read dropped, with no readdatavalid.
REQ-031 address >= DEPTH: writes SHALL be ignored; reads SHALL be accepted and return all zeros with readdatavalid.
REQ-032 readdata SHALL hold its last value when readdatavalid = 0.
REQ-033 While en is low, in-flight reads SHALL be held, then delivered in order once en returns high.

Reset
REQ-034 On reset_n low, asynchronously: readdata = 0, readdatavalid = 0, pipeline valid bits = 0, clear address = 0.
REQ-035 During reset: busy = CLEAR_ON_RESET and waitrequest = CLEAR_ON_RESET.
REQ-036 Memory contents SHALL NOT be altered by reset itself.
REQ-037 Reset asserted mid-CLEAR or mid-read SHALL discard in-flight reads and, if CLEAR_ON_RESET = 1, restart the clear from address 0.

Verification
REQ-038 Bench SHALL cover: defaults, write 0xDEADBEEF to address 5 with byteenable 0xF, then write 0x000000AA with byteenable 0x1, then read 5 -> readdata 0xDEADBEAA one cycle after accept.
REQ-039 Bench SHALL cover: READ_LATENCY = 2, back-to-back reads of addresses 0,1,2 on consecutive cycles -> three consecutive readdatavalid pulses starting 2 cycles after the first accept, in order.
REQ-040 Bench SHALL cover: CLEAR_ON_RESET = 1, DEPTH = 16, release reset_n -> busy and waitrequest high for 16 en cycles; afterwards all 16 words read 0.
REQ-041 Bench SHALL cover: read of address 10240 with DEPTH = 10240 -> readdata 0 with readdatavalid; a write to 10240 leaves address 0 unchanged.
REQ-042 Bench SHALL cover: a read accepted, then clken = 0 for 3 cycles -> readdatavalid stays 0 and no accepts occur; data is delivered on the first cycle after clken returns to 1.
REQ-043 Bench SHALL cover: reset_n pulsed low at clear address 7 -> after release, the clear restarts at 0 and pending reads produce no readdatavalid.
